// File: rtl/byte_packer_8b.sv
// Variable-length byte packer: compacts 0..8 byte beats into dense 8-byte words via a 16-byte accumulator.
// Optional BYTE_PACKER_STATS_EN adds packed_words / stall_cycles counters.
module byte_packer_8b (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [3:0]  in_count,
    input  logic        in_flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [3:0]  out_count
`ifdef BYTE_PACKER_STATS_EN
    ,
    output logic [15:0] packed_words,
    output logic [15:0] stall_cycles
`endif
);

    logic [127:0] acc;
    logic [4:0]   level;
    logic         flush_pending;

    logic         push;
    logic         pop;
    logic [3:0]   level_min;
    logic [3:0]   cnt_eff;
    logic [4:0]   pop_count;
    logic [4:0]   push_count;
    logic [4:0]   level_after_pop;
    logic [4:0]   level_next;
    logic [63:0]  in_masked;
    logic [127:0] acc_next;

    // Outputs depend only on registered state, never on inputs.
    assign in_ready  = (level <= 5'd8) && !flush_pending;
    assign out_valid = (level >= 5'd8) || (flush_pending && (level != 5'd0));
    assign level_min = (level >= 5'd8) ? 4'd8 : level[3:0];
    assign out_count = out_valid ? level_min : 4'd0;

    always_comb begin
        out_data = 64'd0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < out_count)
                out_data[8*k +: 8] = acc[8*k +: 8];
        end
    end

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Illegal counts 9..15 saturate to a full beat.
    assign cnt_eff         = in_count[3] ? 4'd8 : in_count;
    assign pop_count       = pop ? {1'b0, out_count} : 5'd0;
    assign push_count      = push ? {1'b0, cnt_eff} : 5'd0;
    assign level_after_pop = level - pop_count;
    assign level_next      = level_after_pop + push_count;

    always_comb begin
        in_masked = 64'd0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < cnt_eff)
                in_masked[8*k +: 8] = in_data[8*k +: 8];
        end
    end

    // Bytes above level are always zero, so the new beat can simply be OR-ed in.
    always_comb begin
        acc_next = acc >> {pop_count, 3'b000};
        if (push)
            acc_next = acc_next | ({64'd0, in_masked} << {level_after_pop, 3'b000});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc           <= 128'd0;
            level         <= 5'd0;
            flush_pending <= 1'b0;
        end else begin
            acc   <= acc_next;
            level <= level_next;
            if (push && in_flush && (level_next != 5'd0))
                flush_pending <= 1'b1;
            else if (level_next == 5'd0)
                flush_pending <= 1'b0;
        end
    end

`ifdef BYTE_PACKER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            packed_words <= 16'd0;
            stall_cycles <= 16'd0;
        end else begin
            if (pop)
                packed_words <= packed_words + 16'd1;
            if (in_valid && !in_ready)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_byte_packer_8b.sv
// Scoreboard bench for byte_packer_8b: directed beats push hand-computed words, a negedge monitor pops and compares.
module tb_byte_packer_8b;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [3:0]  in_count;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_count;
`ifdef BYTE_PACKER_STATS_EN
    logic [15:0] packed_words;
    logic [15:0] stall_cycles;
`endif

    byte_packer_8b dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
`ifdef BYTE_PACKER_STATS_EN
        ,
        .packed_words (packed_words),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    logic [67:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_word(input logic [63:0] d, input logic [3:0] c);
        exp_q.push_back({c, d});
    endtask

    // Monitor: a handshake at the coming posedge is visible here since inputs move only just after posedge.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word actual=%h/%0d required=none", out_data, out_count);
            end else begin
                logic [67:0] e;
                e = exp_q.pop_front();
                chk("word_data", out_data, e[63:0]);
                chk("word_count", {60'd0, out_count}, {60'd0, e[67:64]});
            end
        end
    end

    // Called just after a posedge; returns just after the posedge where the beat was accepted.
    task automatic send(input logic [63:0] d, input logic [3:0] c, input logic f, output int cyc);
        logic ok;
        ok       = 1'b0;
        cyc      = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_count = c;
        in_flush = f;
        while (!ok && cyc < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_flush = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int cyc;
        int total;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        in_count  = 4'd0;
        in_flush  = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_count", {60'd0, out_count}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Eight single-byte beats with junk in the unused bytes.
        expect_word(64'h0807060504030201, 4'd8);
        for (int i = 0; i < 8; i++)
            send({56'hA5A5A5A5A5A5A5, 8'(i + 1)}, 4'd1, 1'b0, cyc);
        chk("single_latency_valid", {63'd0, out_valid}, 64'd1);
        chk("single_latency_count", {60'd0, out_count}, 64'd8);
        drain();

        // 3,3,3,7 bytes with flush on the last beat.
        expect_word(64'h1716151413121110, 4'd8);
        expect_word(64'h1F1E1D1C1B1A1918, 4'd8);
        send(64'hFFFFFFFFFF121110, 4'd3, 1'b0, cyc);
        send(64'hFFFFFFFFFF151413, 4'd3, 1'b0, cyc);
        send(64'hFFFFFFFFFF181716, 4'd3, 1'b0, cyc);
        send(64'hFF1F1E1D1C1B1A19, 4'd7, 1'b1, cyc);
        drain();
        chk("flush_done_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_done_count", {60'd0, out_count}, 64'd0);
        chk("flush_done_ready", {63'd0, in_ready}, 64'd1);

        // Streaming full beats: every beat must be taken on its first cycle.
        total = 0;
        for (int i = 0; i < 6; i++)
            expect_word(64'h1111111111111111 * 64'(i + 1), 4'd8);
        for (int i = 0; i < 6; i++) begin
            send(64'h1111111111111111 * 64'(i + 1), 4'd8, 1'b0, cyc);
            total += cyc;
        end
        chk("stream_cycles", 64'(total), 64'd6);
        drain();

        // Backpressure: two full beats fill the accumulator.
        out_ready = 1'b0;
        send(64'hA0A1A2A3A4A5A6A7, 4'd8, 1'b0, cyc);
        send(64'hB0B1B2B3B4B5B6B7, 4'd8, 1'b0, cyc);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_out_count", {60'd0, out_count}, 64'd8);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_hold_data", out_data, 64'hA0A1A2A3A4A5A6A7);
        expect_word(64'hA0A1A2A3A4A5A6A7, 4'd8);
        expect_word(64'hB0B1B2B3B4B5B6B7, 4'd8);
        out_ready = 1'b1;
        drain();

        // 5-byte flushed packet blocks the next packet until its tail pops.
        out_ready = 1'b0;
        expect_word(64'h0000006655443322, 4'd5);
        expect_word(64'h0F0E0D0C0B0A0908, 4'd8);
        send(64'h9988776655443322, 4'd5, 1'b1, cyc);
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("flush_block_ready", {63'd0, in_ready}, 64'd0);
                chk("flush_tail_count", {60'd0, out_count}, 64'd5);
                out_ready = 1'b1;
            end
            send(64'h0F0E0D0C0B0A0908, 4'd8, 1'b1, cyc);
        join
        drain();

        // Empty flush at level 0 is swallowed; oversize count acts as 8.
        send(64'hFFFFFFFFFFFFFFFF, 4'd0, 1'b1, cyc);
        chk("empty_flush_valid", {63'd0, out_valid}, 64'd0);
        chk("empty_flush_ready", {63'd0, in_ready}, 64'd1);
        expect_word(64'h1234567890ABCDEF, 4'd8);
        send(64'h1234567890ABCDEF, 4'd12, 1'b1, cyc);
        drain();

        // Reset with 11 bytes held.
        out_ready = 1'b0;
        send(64'hC7C6C5C4C3C2C1C0, 4'd8, 1'b0, cyc);
        send(64'hFFFFFFFFFFD2D1D0, 4'd3, 1'b0, cyc);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out_count", {60'd0, out_count}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef BYTE_PACKER_STATS_EN
        chk("midrst_packed_words", {48'd0, packed_words}, 64'd0);
`endif
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_idle", {63'd0, out_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
